adj_clock_period_meter: RTL and testbench

- Receive-side counterpart of the adjustable clock divider.
- Samples a divided square wave in the ClkInput domain and measures its half-period in ClkInput cycles.
- Reports the divider factor that produced the wave, plus lock and timeout status.
- Used to verify or auto-detect divider settings and to recover the rate of externally divided clocks.

---
 rtl/adj_clock_pkg.sv | 25 ++
 rtl/sync_edge_detect.sv | 49 ++++
 rtl/adj_clock_period_meter.sv | 143 ++++++++++++++
 tb/tb_adj_clock_period_meter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adj_clock_pkg.sv
//==============================================================================
// adj_clock_pkg
// Shared types and helpers for the adjustable clock divider / period meter.
// Revision: 1.0
//==============================================================================
`default_nettype none

package adj_clock_pkg;

  // Period meter sequencing states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } meter_state_t;

  // A divider with factor F holds each level for F+1 input cycles, so the
  // factor is the half-period minus one. Callers truncate to their width.
  function automatic logic [31:0] half_period_to_factor(input logic [31:0] half_period);
    return half_period - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
//==============================================================================
// sync_edge_detect
// Multi-stage synchronizer for an asynchronous level, plus a registered
// one-cycle strobe on every change (both polarities) of the synced level.
// Revision: 1.0
//==============================================================================
`default_nettype none

module sync_edge_detect #(
  parameter int SYNC_STAGES = 2  // must be at least 2
) (
  input  logic ClkInput,
  input  logic ResetN,
  input  logic async_in,
  output logic sync_level,
  output logic edge_strobe
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   edge_q, edge_d;

  // Shift the raw input through the chain; compare the synced level with its
  // one-cycle-old copy to detect any transition.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
    edge_d = sync_q[SYNC_STAGES-1] ^ prev_q;
  end

  // Synchronizer, delayed copy and edge strobe registers; always running
  always_ff @(posedge ClkInput or negedge ResetN) begin
    if (!ResetN) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
    end
  end

  assign sync_level  = sync_q[SYNC_STAGES-1];
  assign edge_strobe = edge_q;

endmodule

`default_nettype wire

// File: rtl/adj_clock_period_meter.sv
//==============================================================================
// adj_clock_period_meter
// Measures the half-period of a divided square wave in ClkInput cycles and
// reports the divider factor that produced it, with lock and timeout status.
// Revision: 1.0
//==============================================================================
`default_nettype none

module adj_clock_period_meter
  import adj_clock_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_TOLERANCE  = 0
) (
  input  logic                       ClkInput,
  input  logic                       ResetN,
  input  logic                       Enable,
  input  logic                       MeasuredSignal,
  output logic [INPUT_BIT_WIDTH-1:0] FactorOut,
  output logic                       FactorValid,
  output logic                       Locked,
  output logic                       Timeout
);

  localparam int          W        = INPUT_BIT_WIDTH;
  localparam logic [W:0]  HALF_ONE = (W+1)'(1);
  localparam logic [W:0]  HALF_MAX = {1'b1, {W{1'b0}}};
  localparam logic [31:0] TOL      = 32'(LOCK_TOLERANCE);

  logic sync_level_unused;
  logic edge_seen;

  meter_state_t  state_q, state_d;
  logic [W:0]    half_count_q, half_count_d;
  logic [W-1:0]  factor_out_q, factor_out_d;
  logic          factor_valid_q, factor_valid_d;
  logic          locked_q, locked_d;
  logic          timeout_q, timeout_d;
  logic          prev_valid_q, prev_valid_d;

  logic [W-1:0]  new_factor;
  logic [W-1:0]  factor_diff;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .ClkInput    (ClkInput),
    .ResetN      (ResetN),
    .async_in    (MeasuredSignal),
    .sync_level  (sync_level_unused),
    .edge_strobe (edge_seen)
  );

  // Candidate factor from the running count and its distance to the last one
  always_comb begin
    new_factor  = W'(half_period_to_factor(32'(half_count_q)));
    factor_diff = (new_factor >= factor_out_q) ? (new_factor - factor_out_q)
                                               : (factor_out_q - new_factor);
  end

  // Next-state, half-period counting and status outputs
  always_comb begin
    state_d        = state_q;
    half_count_d   = half_count_q;
    factor_out_d   = factor_out_q;
    factor_valid_d = 1'b0;
    locked_d       = locked_q;
    timeout_d      = 1'b0;
    prev_valid_d   = prev_valid_q;

    // The count only freezes in IDLE; elsewhere it restarts on every edge
    if (state_q != IDLE) begin
      half_count_d = edge_seen ? HALF_ONE : (half_count_q + HALF_ONE);
    end

    if (!Enable) begin
      state_d      = IDLE;
      locked_d     = 1'b0;
      prev_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_EDGE;
        end
        WAIT_EDGE: begin
          // First edge only aligns the count; nothing is reported
          if (edge_seen) begin
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          // An edge on the overflow cycle still counts: H = 2^W is legal
          if (edge_seen) begin
            factor_out_d   = new_factor;
            factor_valid_d = 1'b1;
            prev_valid_d   = 1'b1;
            locked_d       = prev_valid_q && (32'(factor_diff) <= TOL);
          end else if (half_count_q == HALF_MAX) begin
            // A lost wave invalidates the reference, so lock needs two
            // fresh agreeing measurements once the wave returns.
            timeout_d    = 1'b1;
            locked_d     = 1'b0;
            prev_valid_d = 1'b0;
            state_d      = WAIT_EDGE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge ClkInput or negedge ResetN) begin
    if (!ResetN) begin
      state_q        <= IDLE;
      half_count_q   <= '0;
      factor_out_q   <= '0;
      factor_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
      prev_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      half_count_q   <= half_count_d;
      factor_out_q   <= factor_out_d;
      factor_valid_q <= factor_valid_d;
      locked_q       <= locked_d;
      timeout_q      <= timeout_d;
      prev_valid_q   <= prev_valid_d;
    end
  end

  assign FactorOut   = factor_out_q;
  assign FactorValid = factor_valid_q;
  assign Locked      = locked_q;
  assign Timeout     = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_adj_clock_period_meter.sv
//==============================================================================
// tb_adj_clock_period_meter
// Self-checking bench: divider-style stimulus with random segments, compared
// every cycle against a cycle-index based behavioural model, plus literal
// expectations for the key scenarios.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_adj_clock_period_meter;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int TOL  = 0;
  localparam int HMAX = 256;

  logic         ClkInput = 1'b0;
  logic         ResetN;
  logic         Enable;
  logic         MeasuredSignal;
  logic [W-1:0] FactorOut;
  logic         FactorValid;
  logic         Locked;
  logic         Timeout;

  adj_clock_period_meter #(
    .INPUT_BIT_WIDTH (W),
    .SYNC_STAGES     (S),
    .LOCK_TOLERANCE  (TOL)
  ) dut (
    .ClkInput       (ClkInput),
    .ResetN         (ResetN),
    .Enable         (Enable),
    .MeasuredSignal (MeasuredSignal),
    .FactorOut      (FactorOut),
    .FactorValid    (FactorValid),
    .Locked         (Locked),
    .Timeout        (Timeout)
  );

  always #5 ClkInput = ~ClkInput;

  int checks   = 0;
  int failures = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // The meter sees an input change S+1 clocks after it is first sampled; the
  // half-period is the distance in clock indices between consecutive edges.
  bit hist [0:63];
  int mcyc      = 0;
  bit m_armed   = 0;
  bit m_aligned = 0;
  int m_last    = 0;
  int m_factor  = 0;
  bit m_valid   = 0;
  bit m_locked  = 0;
  bit m_to      = 0;
  bit m_pv      = 0;

  function automatic bit samp(int k);
    if (k < 0) return 1'b0;
    return hist[k % 64];
  endfunction

  always @(posedge ClkInput or negedge ResetN) begin
    if (!ResetN) begin
      mcyc = 0; m_armed = 0; m_aligned = 0; m_last = 0;
      m_factor = 0; m_valid = 0; m_locked = 0; m_to = 0; m_pv = 0;
    end else begin
      bit ed;
      int h, nf, d;
      hist[mcyc % 64] = MeasuredSignal;
      ed = samp(mcyc - S - 1) ^ samp(mcyc - S - 2);
      m_valid = 0;
      m_to    = 0;
      if (!Enable) begin
        m_armed = 0; m_aligned = 0; m_locked = 0; m_pv = 0;
      end else if (!m_armed) begin
        m_armed = 1;
      end else if (!m_aligned) begin
        if (ed) begin
          m_aligned = 1;
          m_last    = mcyc;
        end
      end else begin
        h = mcyc - m_last;
        if (ed) begin
          nf = (h - 1) % HMAX;
          d  = nf - m_factor;
          if (d < 0) d = -d;
          m_locked = m_pv && (d <= TOL);
          m_factor = nf;
          m_valid  = 1;
          m_pv     = 1;
          m_last   = mcyc;
        end else if (h == HMAX) begin
          m_to = 1; m_locked = 0; m_pv = 0; m_aligned = 0;
        end
      end
      mcyc++;
    end
  end

  // ---------------- per-cycle comparison ----------------
  bit cmp_on = 0;

  always @(negedge ClkInput) begin
    if (cmp_on) begin
      check("cyc_factor_out",   int'(FactorOut),   m_factor);
      check("cyc_factor_valid", int'(FactorValid), int'(m_valid));
      check("cyc_locked",       int'(Locked),      int'(m_locked));
      check("cyc_timeout",      int'(Timeout),     int'(m_to));
    end
  end

  // ---------------- observation counters ----------------
  int cyc = 0, valid_cnt = 0, to_cnt = 0, last_valid_cyc = 0, last_to_cyc = 0;

  always @(negedge ClkInput) begin
    cyc++;
    if (FactorValid === 1'b1) begin valid_cnt++; last_valid_cyc = cyc; end
    if (Timeout === 1'b1)     begin to_cnt++;    last_to_cyc    = cyc; end
  end

  // ---------------- stimulus ----------------
  int div_f  = 5;
  bit gen_on = 0;
  int dcnt   = 0;

  task automatic step();
    @(negedge ClkInput);
    #1;
    if (gen_on) begin
      if (dcnt >= div_f) begin
        MeasuredSignal = ~MeasuredSignal;
        dcnt = 0;
      end else begin
        dcnt++;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int k;
    int start;
    k = 0;
    start = valid_cnt;
    while (valid_cnt == start && k < budget) begin
      step();
      k++;
    end
    if (valid_cnt == start) check({tag, "_no_valid"}, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    int c0, v0, t0, guard, r;
    ResetN = 1'b0; Enable = 1'b0; MeasuredSignal = 1'b0;
    #12;
    check("reset_factor_out", int'(FactorOut), 0);
    check("reset_valid",      int'(FactorValid), 0);
    check("reset_locked",     int'(Locked), 0);
    check("reset_timeout",    int'(Timeout), 0);
    cmp_on = 1;
    run(2);

    // F=5: first edge aligns, then factor 5 every 6 cycles, lock on second
    ResetN = 1'b1; Enable = 1'b1; div_f = 5; dcnt = 0; gen_on = 1;
    wait_valid(60, "f5_first");
    check("f5_first_factor", int'(FactorOut), 5);
    check("f5_first_locked", int'(Locked), 0);
    c0 = last_valid_cyc;
    wait_valid(20, "f5_second");
    check("f5_interval", last_valid_cyc - c0, 6);
    check("f5_second_locked", int'(Locked), 1);

    // F=0: a measurement every cycle
    div_f = 0;
    run(12);
    check("f0_valid", int'(FactorValid), 1);
    check("f0_factor", int'(FactorOut), 0);
    check("f0_locked", int'(Locked), 1);
    v0 = valid_cnt;
    run(4);
    check("f0_valid_count", valid_cnt - v0, 4);

    // F=255: half-period equals the limit, edge wins, no timeout
    div_f = 255;
    t0 = to_cnt;
    run(256 * 4);
    check("f255_factor", int'(FactorOut), 255);
    check("f255_no_timeout", to_cnt - t0, 0);
    check("f255_locked", int'(Locked), 1);

    // Stuck input after lock: timeout 256 cycles after the last measurement
    div_f = 5;
    run(40);
    check("stuck_pre_locked", int'(Locked), 1);
    gen_on = 0;
    t0 = to_cnt;
    guard = 0;
    while (to_cnt == t0 && guard < 400) begin step(); guard++; end
    check("stuck_timeout_seen", to_cnt - t0, 1);
    check("stuck_timeout_gap", last_to_cyc - last_valid_cyc, 256);
    check("stuck_locked", int'(Locked), 0);
    check("stuck_factor_hold", int'(FactorOut), 5);
    dcnt = 0; gen_on = 1;
    wait_valid(40, "resume_first");
    check("resume_first_factor", int'(FactorOut), 5);
    check("resume_first_locked", int'(Locked), 0);
    wait_valid(20, "resume_second");
    check("resume_second_locked", int'(Locked), 1);

    // Factor change 5 -> 9 while locked
    run(20);
    div_f = 9;
    guard = 0;
    do begin
      wait_valid(40, "f9_wait");
      guard++;
    end while (FactorOut == 8'd5 && guard < 6);
    check("f9_first_factor", int'(FactorOut), 9);
    check("f9_first_locked", int'(Locked), 0);
    wait_valid(30, "f9_second");
    check("f9_second_factor", int'(FactorOut), 9);
    check("f9_second_locked", int'(Locked), 1);

    // Enable dropped mid-half-period
    run(3);
    Enable = 1'b0;
    v0 = valid_cnt; t0 = to_cnt;
    step();
    check("dis_locked", int'(Locked), 0);
    run(15);
    check("dis_no_valid", valid_cnt - v0, 0);
    check("dis_no_timeout", to_cnt - t0, 0);
    Enable = 1'b1;
    v0 = valid_cnt;
    run(9);
    check("reen_align_no_valid", valid_cnt - v0, 0);
    wait_valid(40, "reen_first");
    check("reen_factor", int'(FactorOut), 9);

    // Asynchronous reset between clock edges while measuring
    run(25);
    check("prereset_locked", int'(Locked), 1);
    #3;
    ResetN = 1'b0;
    #1;
    check("areset_factor_out", int'(FactorOut), 0);
    check("areset_valid",      int'(FactorValid), 0);
    check("areset_locked",     int'(Locked), 0);
    check("areset_timeout",    int'(Timeout), 0);
    gen_on = 0; MeasuredSignal = 1'b0; dcnt = 0; div_f = 3;
    run(3);
    ResetN = 1'b1; gen_on = 1;
    wait_valid(40, "f3_first");
    check("f3_first_factor", int'(FactorOut), 3);
    c0 = last_valid_cyc;
    wait_valid(20, "f3_second");
    check("f3_interval", last_valid_cyc - c0, 4);
    check("f3_locked", int'(Locked), 1);

    // Randomized segments: factor changes, long factors, stalls, enable drops
    for (int seg = 0; seg < 25; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        div_f = $urandom_range(0, 12);
        run($urandom_range(20, 120));
      end else if (r < 7) begin
        div_f = $urandom_range(240, 255);
        run($urandom_range(300, 700));
      end else if (r < 8) begin
        gen_on = 0;
        run($urandom_range(200, 300));
        gen_on = 1;
      end else begin
        Enable = 1'b0;
        run($urandom_range(1, 6));
        Enable = 1'b1;
        run(30);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
